sequence_encode: RTL

SEQUENCE_ENCODE -- requirements
Module: sequence_encode

---
 rtl/ISO14443A_pkg.sv | 16 +
 rtl/subcarrier_gen.sv | 12 +
 rtl/sequence_encode.sv | 90 +++++++++
 3 files changed

// File: rtl/ISO14443A_pkg.sv
// ISO14443A_pkg: shared PICC->PCD sequence type and encoder timing defaults.
package ISO14443A_pkg;
    typedef enum logic [1:0] {
        SEQ_D = 2'd0,
        SEQ_E = 2'd1,
        SEQ_F = 2'd2
    } PICCBitSequence;
    typedef enum logic {ST_IDLE, ST_ACTIVE} enc_state_t;
    localparam int BIT_LEN_DEF = 128;
    localparam int SUBCARRIER_HALF_DEF = 8;
    localparam int TICK_W = 7;
    // Anything other than D or E carries no modulation, so it collapses to F.
    function automatic PICCBitSequence legalize(input PICCBitSequence s);
        return (s == SEQ_D || s == SEQ_E) ? s : SEQ_F;
    endfunction
endpackage

// File: rtl/subcarrier_gen.sv
// subcarrier_gen: maps a bit-period tick to the fc/16 subcarrier level.
module subcarrier_gen
    import ISO14443A_pkg::*;
#(
    parameter int SUBCARRIER_HALF = SUBCARRIER_HALF_DEF
) (
    input  logic [TICK_W-1:0] tick,
    output logic              level
);
    localparam int PERIOD = 2 * SUBCARRIER_HALF;
    always_comb level = (int'(tick) % PERIOD) < SUBCARRIER_HALF;
endmodule

// File: rtl/sequence_encode.sv
// sequence_encode: Manchester-style load modulation of D/E/F sequences with a one-entry holding buffer.
module sequence_encode
    import ISO14443A_pkg::*;
#(
    parameter int BIT_LEN         = BIT_LEN_DEF,
    parameter int SUBCARRIER_HALF = SUBCARRIER_HALF_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  PICCBitSequence seq,
    input  logic           seq_valid,
    output logic           seq_ready,
    output logic           lm_out,
    output logic           idle
);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(BIT_LEN - 1);
    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(BIT_LEN / 2);
    enc_state_t        state, state_n;
    PICCBitSequence    cur, cur_n, hold_seq, hold_n, seq_in;
    logic              hold_valid, hold_valid_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic              out_active, out_active_n, lm_n;
    logic              sc_level, in_half, xfer, last;

    subcarrier_gen #(.SUBCARRIER_HALF(SUBCARRIER_HALF)) u_sc (
        .tick  (tick),
        .level (sc_level)
    );

    assign seq_in  = legalize(seq);
    assign xfer    = seq_valid && seq_ready;
    assign last    = state == ST_ACTIVE && tick == LAST_TICK;
    assign in_half = cur == SEQ_D ? tick < HALF_TICK : cur == SEQ_E ? tick >= HALF_TICK : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur        <= SEQ_F;
            hold_seq   <= SEQ_F;
            hold_valid <= 1'b0;
            tick       <= '0;
            lm_out     <= 1'b0;
            out_active <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            hold_seq   <= hold_n;
            hold_valid <= hold_valid_n;
            tick       <= tick_n;
            lm_out     <= lm_n;
            out_active <= out_active_n;
        end
    end

    // At the last tick the next bit is taken from the buffer, else straight from the input.
    always_comb begin
        state_n      = state;
        cur_n        = cur;
        hold_n       = hold_seq;
        hold_valid_n = hold_valid;
        tick_n       = '0;
        if (state == ST_IDLE) begin
            if (xfer) begin
                state_n = ST_ACTIVE;
                cur_n   = seq_in;
            end
        end else if (!last) begin
            tick_n = tick + 1'b1;
            if (xfer) begin
                hold_n       = seq_in;
                hold_valid_n = 1'b1;
            end
        end else if (hold_valid) begin
            cur_n        = hold_seq;
            hold_valid_n = 1'b0;
        end else if (xfer) begin
            cur_n = seq_in;
        end else begin
            state_n = ST_IDLE;
        end
    end

    // idle tracks the registered output stage so it lines up with lm_out.
    always_comb begin
        seq_ready    = !hold_valid;
        idle         = !out_active && !hold_valid;
        lm_n         = state == ST_ACTIVE && in_half && sc_level;
        out_active_n = state == ST_ACTIVE;
    end
endmodule
